// File: rtl/video_stream_tx.sv
// Frame-based video transmitter: paces a pixel source into field/line valid
// timing with fixed lead-in, horizontal and vertical blanking.
module video_stream_tx #(
  parameter int unsigned DW           = 14,
  parameter int unsigned IMAGE_WIDTH  = 640,
  parameter int unsigned IMAGE_HEIGHT = 512,
  parameter int unsigned H_BLANK      = 160,
  parameter int unsigned FV_LEAD      = 32,
  parameter int unsigned V_BLANK      = 1000
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_enable,
  input  logic          i_pix_vld,
  input  logic [DW-1:0] i_pix_data,
  output logic          o_pix_rdy,
  output logic          o_field_vld,
  output logic          o_line_vld,
  output logic [DW-1:0] o_img_data,
  output logic          o_frame_done,
  output logic          o_underrun
);

  typedef enum logic [2:0] {IDLE, LEAD, ACTIVE, HBLANK, VBLANK} state_t;

  localparam int unsigned TMAX = (FV_LEAD > H_BLANK) ?
                                 ((FV_LEAD > V_BLANK) ? FV_LEAD : V_BLANK) :
                                 ((H_BLANK > V_BLANK) ? H_BLANK : V_BLANK);
  localparam int unsigned CW = $clog2(IMAGE_WIDTH + 1);
  localparam int unsigned RW = $clog2(IMAGE_HEIGHT + 1);
  localparam int unsigned TW = $clog2(TMAX + 1);

  state_t        state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [TW-1:0] tmr;

  assign o_pix_rdy = (state == ACTIVE);

  // Outputs reflect the state of the previous cycle; timing never stalls on the source.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state        <= IDLE;
      col          <= '0;
      row          <= '0;
      tmr          <= '0;
      o_field_vld  <= 1'b0;
      o_line_vld   <= 1'b0;
      o_img_data   <= '0;
      o_frame_done <= 1'b0;
      o_underrun   <= 1'b0;
    end else begin
      o_field_vld  <= (state == LEAD) || (state == ACTIVE) || (state == HBLANK);
      o_line_vld   <= (state == ACTIVE);
      o_img_data   <= ((state == ACTIVE) && i_pix_vld) ? i_pix_data : '0;
      o_frame_done <= (state == VBLANK) && o_field_vld;

      case (state)
        IDLE: begin
          if (i_enable) begin
            state      <= LEAD;
            tmr        <= '0;
            col        <= '0;
            row        <= '0;
            o_underrun <= 1'b0;
          end
        end
        LEAD: begin
          if (tmr == TW'(FV_LEAD - 1)) begin
            state <= ACTIVE;
            tmr   <= '0;
            col   <= '0;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        ACTIVE: begin
          if (!i_pix_vld) o_underrun <= 1'b1;
          if (col == CW'(IMAGE_WIDTH - 1)) begin
            col <= '0;
            tmr <= '0;
            // Last line goes straight to vertical blanking
            if (row < RW'(IMAGE_HEIGHT - 1)) begin
              row   <= row + 1'b1;
              state <= HBLANK;
            end else begin
              row   <= '0;
              state <= VBLANK;
            end
          end else begin
            col <= col + 1'b1;
          end
        end
        HBLANK: begin
          if (tmr == TW'(H_BLANK - 1)) begin
            state <= ACTIVE;
            tmr   <= '0;
            col   <= '0;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        VBLANK: begin
          if (tmr == TW'(V_BLANK - 1)) begin
            state <= IDLE;
            tmr   <= '0;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_video_stream_tx.sv
// Scoreboard bench for video_stream_tx: a frame-position model predicts every
// output each cycle; a negedge monitor pops and compares.
module tb_video_stream_tx;

  localparam int DW    = 8;
  localparam int W     = 4;
  localparam int H     = 3;
  localparam int HB    = 2;
  localparam int LEAD  = 3;
  localparam int VB    = 5;
  localparam int F     = LEAD + H * (W + HB) - HB;  // field-high cycles
  localparam int PER   = F + VB;                    // frame cycles excluding IDLE
  localparam int FIELD_LEN = 19;

  typedef struct packed {
    logic          field;
    logic          line;
    logic [DW-1:0] data;
    logic          done;
    logic          und;
    logic          rdy;
  } obs_t;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b0;
  logic          i_enable = 1'b0;
  logic          i_pix_vld = 1'b0;
  logic [DW-1:0] i_pix_data = '0;
  logic          o_pix_rdy, o_field_vld, o_line_vld, o_frame_done, o_underrun;
  logic [DW-1:0] o_img_data;

  video_stream_tx #(
    .DW(DW), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H),
    .H_BLANK(HB), .FV_LEAD(LEAD), .V_BLANK(VB)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_enable(i_enable),
    .i_pix_vld(i_pix_vld), .i_pix_data(i_pix_data),
    .o_pix_rdy(o_pix_rdy), .o_field_vld(o_field_vld), .o_line_vld(o_line_vld),
    .o_img_data(o_img_data), .o_frame_done(o_frame_done), .o_underrun(o_underrun)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  obs_t exp_q[$];

  // Model: idle flag plus position within the frame counted from LEAD entry
  bit            m_idle = 1'b1;
  int            m_pos  = 0;
  logic          r_field = 1'b0, r_line = 1'b0, r_done = 1'b0, r_und = 1'b0;
  logic [DW-1:0] r_data = '0;

  function automatic bit pos_active(int p);
    return (p >= LEAD) && (p < F) && (((p - LEAD) % (W + HB)) < W);
  endfunction

  function automatic bit cur_active();
    return !m_idle && pos_active(m_pos);
  endfunction

  function automatic int cur_row();
    return (m_pos - LEAD) / (W + HB);
  endfunction

  function automatic int cur_col();
    return (m_pos - LEAD) % (W + HB);
  endfunction

  task automatic step(input bit en, input bit vld, input bit rst, input logic [DW-1:0] d);
    obs_t e;
    bit act;
    i_enable   = en;
    i_pix_vld  = vld;
    i_rst      = rst;
    i_pix_data = d;
    act = cur_active();
    e = '{field: r_field, line: r_line, data: r_data, done: r_done, und: r_und, rdy: act};
    exp_q.push_back(e);
    if (!rst) begin
      r_field = 1'b0; r_line = 1'b0; r_data = '0; r_done = 1'b0; r_und = 1'b0;
      m_idle  = 1'b1;
    end else begin
      r_field = !m_idle && (m_pos < F);
      r_line  = act;
      r_data  = (act && vld) ? d : '0;
      r_done  = !m_idle && (m_pos == F);
      if (m_idle) begin
        if (en) begin
          m_idle = 1'b0;
          m_pos  = 0;
          r_und  = 1'b0;
        end
      end else begin
        if (act && !vld) r_und = 1'b1;
        if (m_pos == PER - 1) m_idle = 1'b1;
        else m_pos++;
      end
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && !m_idle; n++) step(1'b0, 1'b1, 1'b1, DW'($urandom));
    for (int n = 0; n < 3; n++) step(1'b0, 1'b0, 1'b1, '0);
  endtask

  // Per-cycle output comparison against the scoreboard
  always @(negedge i_clk) begin
    obs_t e, a;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{field: o_field_vld, line: o_line_vld, data: o_img_data,
            done: o_frame_done, und: o_underrun, rdy: o_pix_rdy};
      n_checks++;
      if (a === e) n_pass++;
      else $display("FAIL outputs cyc=%0d got fld=%b ln=%b data=%0h done=%b und=%b rdy=%b exp fld=%b ln=%b data=%0h done=%b und=%b rdy=%b",
                    cyc, a.field, a.line, a.data, a.done, a.und, a.rdy,
                    e.field, e.line, e.data, e.done, e.und, e.rdy);
    end
  end

  // Field length check for frames not cut short by reset
  bit prev_fld = 1'b0;
  bit aborted  = 1'b1;
  int run      = 0;
  always @(negedge i_clk) begin
    if (o_field_vld === 1'b1 && !prev_fld) begin
      run = 0;
      aborted = 1'b0;
    end
    if (i_rst === 1'b0) aborted = 1'b1;
    if (o_field_vld === 1'b1) run++;
    if (prev_fld && o_field_vld !== 1'b1 && !aborted) begin
      n_checks++;
      if (run == FIELD_LEN) n_pass++;
      else $display("FAIL field_len got %0d exp %0d", run, FIELD_LEN);
    end
    prev_fld = (o_field_vld === 1'b1);
  end

  initial begin
    logic [DW-1:0] pix;
    bit dropped;
    @(posedge i_clk);
    #1;
    // Reset, then enable held low with a valid source present
    for (int n = 0; n < 3; n++) step(1'b0, 1'b1, 1'b0, '0);
    for (int n = 0; n < 30; n++) step(1'b0, 1'b1, 1'b1, DW'($urandom));

    // Continuous source, two back-to-back frames, pixels 1..12 each frame
    pix = 8'd1;
    for (int n = 0; n < 2 * (PER + 1); n++) begin
      if (cur_active()) begin
        step(1'b1, 1'b1, 1'b1, pix);
        pix = (pix == 8'd12) ? 8'd1 : pix + 8'd1;
      end else begin
        step(1'b1, 1'b1, 1'b1, 8'hEE);
      end
    end
    drain();

    // Source starves on the 2nd pixel of line 2, then a second frame clears the flag
    for (int n = 0; n < 2 * (PER + 1); n++) begin
      if (cur_active() && cur_row() == 1 && cur_col() == 1 && n < PER)
        step(1'b1, 1'b0, 1'b1, 8'h55);
      else
        step(1'b1, 1'b1, 1'b1, DW'($urandom_range(1, 255)));
    end
    drain();

    // Enable dropped during line 1: frame must still complete
    dropped = 1'b0;
    for (int n = 0; n < PER + 30; n++) begin
      if (cur_active() && cur_row() == 0 && cur_col() == 2) dropped = 1'b1;
      step(!dropped, 1'b1, 1'b1, DW'($urandom));
    end

    // One-cycle reset during line 2, then a full restart
    dropped = 1'b0;
    for (int n = 0; n < 200 && !dropped; n++) begin
      if (cur_active() && cur_row() == 1 && cur_col() == 1) begin
        step(1'b1, 1'b1, 1'b0, 8'h11);
        dropped = 1'b1;
      end else begin
        step(1'b1, 1'b1, 1'b1, DW'($urandom));
      end
    end
    for (int n = 0; n < PER + 10; n++) step(1'b1, 1'b1, 1'b1, DW'($urandom));
    drain();

    // Randomised enable, source gaps, data and occasional resets
    for (int n = 0; n < 3000; n++)
      step(($urandom % 4) != 0, ($urandom % 8) != 0, ($urandom % 300) != 0, DW'($urandom));
    drain();

    @(negedge i_clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
